max_frame_accumulator: RTL

Streaming reduction stage that sits directly downstream of the `maximum` lane-reduction block. It consumes that block's per-beat fp16 results, framed by `istart`/`ilast`, and keeps a running maximum across every beat of a frame. It emits exactly one fp16 result per frame, together with the frame's beat count, on a single-entry registered output with ready/valid backpressure. This completes an element-wise-then-message-wide MAX reduction.

---
 rtl/mpi_fp16_pkg.sv | 29 ++
 rtl/fp16_max2.sv | 18 +
 rtl/max_frame_accumulator.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mpi_fp16_pkg.sv
// Shared fp16 helpers for the MPI reduction datapath.
// Contents:
//   FP16_NEG_INF / FP16_QNAN : identity value for max and the canonical NaN
//   fp16_is_nan              : exponent all ones with a non-zero mantissa
//   fp16_order_key           : maps fp16 onto an unsigned key that sorts in
//                              numeric order (-inf lowest, -0 below +0)
//   acc_state_t              : frame accumulator state encoding
package mpi_fp16_pkg;

    localparam logic [15:0] FP16_NEG_INF = 16'hFC00;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } acc_state_t;

    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != 10'h000);
    endfunction

    // Negative values are bit-inverted so a larger magnitude gives a smaller
    // key; positive values get the sign bit set so they sort above all negatives.
    function automatic logic [15:0] fp16_order_key(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

endpackage

// File: rtl/fp16_max2.sv
// Combinational two-input fp16 maximum.
// Ports:
//   a, b : fp16 operands
//   y    : the operand with the larger order key (a on a tie)
// NaN operands are not special-cased; callers track NaN separately.
module fp16_max2
    import mpi_fp16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);

    always_comb begin
        y = (fp16_order_key(b) > fp16_order_key(a)) ? b : a;
    end

endmodule

// File: rtl/max_frame_accumulator.sv
// Frame-wide fp16 MAX reduction with a single-entry registered output.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   idata/ivalid/iready    : per-beat fp16 input stream
//   istart/ilast           : frame delimiters on the input stream
//   odata/ocount           : frame maximum and saturating beat count
//   ovalid/oready          : output handshake; result holds while stalled
//   ostart/olast           : mirror ovalid (one-beat output frame)
//   err                    : one-cycle pulse after a protocol violation
module max_frame_accumulator
    import mpi_fp16_pkg::*;
#(
    parameter int unsigned COUNT_W = 16,
    parameter logic [15:0] NEG_INF = FP16_NEG_INF,
    parameter logic [15:0] QNAN    = FP16_QNAN
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [15:0]        idata,
    input  logic               ivalid,
    output logic               iready,
    input  logic               istart,
    input  logic               ilast,
    output logic [15:0]        odata,
    output logic [COUNT_W-1:0] ocount,
    output logic               ovalid,
    input  logic               oready,
    output logic               ostart,
    output logic               olast,
    output logic               err
);

    acc_state_t         state;
    logic [15:0]        acc;
    logic [COUNT_W-1:0] cnt;
    logic               nan_seen;

    logic               accept;
    logic               open;
    logic               take;
    logic               bad;
    logic [15:0]        max_y;
    logic [15:0]        acc_n;
    logic [COUNT_W-1:0] cnt_n;
    logic               nan_n;

    fp16_max2 u_max2 (
        .a (acc),
        .b (idata),
        .y (max_y)
    );

    // HOLD only accepts a beat in the cycle its result is drained, so an
    // accepted beat never sees an open frame while in HOLD.
    assign iready = aresetn && ((state != HOLD) || oready);
    assign accept = ivalid && iready;
    assign ostart = ovalid;
    assign olast  = ovalid;

    always_comb begin
        open  = (state == ACCUM);
        take  = 1'b0;
        bad   = 1'b0;
        acc_n = acc;
        cnt_n = cnt;
        nan_n = nan_seen;
        if (istart) begin
            take  = 1'b1;
            bad   = open;
            acc_n = idata;
            cnt_n = COUNT_W'(1);
            nan_n = fp16_is_nan(idata);
        end else if (open) begin
            take  = 1'b1;
            acc_n = max_y;
            cnt_n = (cnt == '1) ? cnt : cnt + COUNT_W'(1);
            nan_n = nan_seen | fp16_is_nan(idata);
        end else begin
            bad   = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            acc      <= NEG_INF;
            cnt      <= '0;
            nan_seen <= 1'b0;
            odata    <= '0;
            ocount   <= '0;
            ovalid   <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= 1'b0;
            if ((state == HOLD) && oready) begin
                ovalid <= 1'b0;
                state  <= IDLE;
            end
            if (accept) begin
                err <= bad;
                if (take) begin
                    if (ilast) begin
                        odata    <= nan_n ? QNAN : acc_n;
                        ocount   <= cnt_n;
                        ovalid   <= 1'b1;
                        state    <= HOLD;
                        acc      <= NEG_INF;
                        cnt      <= '0;
                        nan_seen <= 1'b0;
                    end else begin
                        acc      <= acc_n;
                        cnt      <= cnt_n;
                        nan_seen <= nan_n;
                        state    <= ACCUM;
                    end
                end
            end
        end
    end

endmodule
